// File: rtl/resp_misr_checker_pkg.sv
// Shared definitions for the response MISR checker: FSM state encoding and
// default parameter values used by the top and the MISR step logic.
// No logic; constants and types only.
package resp_misr_checker_pkg;

    // Default widths and polynomial; the top exposes these as overridable parameters.
    localparam int unsigned DEF_RESP_W = 8;
    localparam int unsigned DEF_MISR_W = 16;
    localparam logic [15:0] DEF_POLY   = 16'h1021;
    localparam int unsigned DEF_CNT_W  = 16;

    // Compaction run sequencing.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2
    } state_e;

endpackage

// File: rtl/resp_misr_checker_misr_step.sv
// MISR next-state step: shift left, fold in POLY when the MSB drops out, then XOR in the response word.
// Latency: purely combinational (0 cycles).
// Backpressure: none; the caller decides when to register o_sig.
//
// Ports:
//   i_sig  - current signature
//   i_resp - response word, zero-extended to MISR_W before folding in
//   o_sig  - signature after absorbing i_resp
module misr_step
    import resp_misr_checker_pkg::*;
#(
    parameter int unsigned       MISR_W = DEF_MISR_W,
    parameter int unsigned       RESP_W = DEF_RESP_W,
    parameter logic [MISR_W-1:0] POLY   = MISR_W'(DEF_POLY)
) (
    input  logic [MISR_W-1:0] i_sig,
    input  logic [RESP_W-1:0] i_resp,
    output logic [MISR_W-1:0] o_sig
);

    logic [MISR_W-1:0] w_shift;
    logic [MISR_W-1:0] w_fb;
    logic [MISR_W-1:0] w_resp_ext;

    assign w_shift    = {i_sig[MISR_W-2:0], 1'b0};
    // Feedback is keyed on the bit shifted out, i.e. the pre-shift MSB.
    assign w_fb       = i_sig[MISR_W-1] ? POLY : '0;
    assign w_resp_ext = {{(MISR_W-RESP_W){1'b0}}, i_resp};
    assign o_sig      = w_shift ^ w_fb ^ w_resp_ext;

endmodule

// File: rtl/resp_misr_checker.sv
// Response compactor: absorbs n_patterns valid samples into a MISR, then compares against golden_sig.
// Latency: final-sample edge -> one CHECK cycle -> one-cycle done pulse with pass registered.
// Backpressure: none; samples are taken whenever resp_valid is high in RUN, gaps simply stall the run.
//
// Ports:
//   I1470_clk, I1477_rst   - clock, async active-low reset
//   start, abort           - begin a run (IDLE only) / cancel a run (abort wins over start)
//   n_patterns, sig_seed   - sample count and initial signature, captured on start
//   golden_sig             - expected signature, sampled in CHECK
//   resp_valid, resp_data  - sample stream from the circuit under test
//   busy, done, pass       - run in progress / completion pulse / held comparison result
//   signature, rare_cnt    - live MISR contents / saturating count of samples with bit0 set
module resp_misr_checker
    import resp_misr_checker_pkg::*;
#(
    parameter int unsigned       RESP_W = DEF_RESP_W,
    parameter int unsigned       MISR_W = DEF_MISR_W,
    parameter logic [MISR_W-1:0] POLY   = MISR_W'(DEF_POLY),
    parameter int unsigned       CNT_W  = DEF_CNT_W
) (
    input  logic              I1470_clk,
    input  logic              I1477_rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  n_patterns,
    input  logic [MISR_W-1:0] sig_seed,
    input  logic [MISR_W-1:0] golden_sig,
    input  logic              resp_valid,
    input  logic [RESP_W-1:0] resp_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MISR_W-1:0] signature,
    output logic [CNT_W-1:0]  rare_cnt
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [MISR_W-1:0] r_sig;
    logic [MISR_W-1:0] w_sig_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_npat;
    logic [CNT_W-1:0]  r_rare;
    logic              r_pass;
    logic              r_done;

    logic              w_busy;
    logic              w_load;
    logic              w_accept;
    logic              w_last;
    logic              w_check;
    logic [CNT_W-1:0]  w_cnt_inc;

    assign w_busy    = (r_state != ST_IDLE);
    // Abort beats start even in IDLE, so a simultaneous pair never launches a run.
    assign w_load    = (r_state == ST_IDLE) && start && !abort;
    assign w_accept  = (r_state == ST_RUN) && resp_valid && !abort;
    // Comparing count+1 rather than count lets n_patterns = all-ones finish without overflow.
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_last    = w_accept && (w_cnt_inc == r_npat);
    assign w_check   = (r_state == ST_CHECK) && !abort;

    misr_step #(
        .MISR_W (MISR_W),
        .RESP_W (RESP_W),
        .POLY   (POLY)
    ) u_misr_step (
        .i_sig  (r_sig),
        .i_resp (resp_data),
        .o_sig  (w_sig_nxt)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_load) begin
                    w_state_nxt = (n_patterns == '0) ? ST_CHECK : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_last) begin
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge I1470_clk or negedge I1477_rst) begin
        if (!I1477_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Signature: seeded on start, stepped per accepted sample, otherwise held (including through abort).
    always_ff @(posedge I1470_clk or negedge I1477_rst) begin
        if (!I1477_rst) begin
            r_sig <= '0;
        end else if (w_load) begin
            r_sig <= sig_seed;
        end else if (w_accept) begin
            r_sig <= w_sig_nxt;
        end
    end

    always_ff @(posedge I1470_clk or negedge I1477_rst) begin
        if (!I1477_rst) begin
            r_cnt  <= '0;
            r_npat <= '0;
        end else if (w_load) begin
            r_cnt  <= '0;
            r_npat <= n_patterns;
        end else if (w_accept) begin
            r_cnt  <= w_cnt_inc;
        end
    end

    // Rare-event counter sticks at all-ones instead of wrapping.
    always_ff @(posedge I1470_clk or negedge I1477_rst) begin
        if (!I1477_rst) begin
            r_rare <= '0;
        end else if (w_load) begin
            r_rare <= '0;
        end else if (w_accept && resp_data[0] && (r_rare != '1)) begin
            r_rare <= r_rare + CNT_W'(1);
        end
    end

    // pass is cleared by start and by abort of an active run, and set only by an un-aborted CHECK.
    always_ff @(posedge I1470_clk or negedge I1477_rst) begin
        if (!I1477_rst) begin
            r_pass <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_check;
            if (w_load || (w_busy && abort)) begin
                r_pass <= 1'b0;
            end else if (w_check) begin
                r_pass <= (r_sig == golden_sig);
            end
        end
    end

    assign busy      = w_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign signature = r_sig;
    assign rare_cnt  = r_rare;

endmodule

// File: tb/tb_resp_misr_checker.sv
module tb_resp_misr_checker;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] n_patterns;
    logic [15:0] sig_seed;
    logic [15:0] golden_sig;
    logic        resp_valid;
    logic [7:0]  resp_data;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] signature;
    logic [15:0] rare_cnt;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] sig;
        logic        pass;
        logic [15:0] rare;
    } exp_t;

    exp_t exp_q[$];

    logic [7:0] d_arr[16];
    int         g_arr[16];

    resp_misr_checker dut (
        .I1470_clk  (clk),
        .I1477_rst  (rst_n),
        .start      (start),
        .abort      (abort),
        .n_patterns (n_patterns),
        .sig_seed   (sig_seed),
        .golden_sig (golden_sig),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .signature  (signature),
        .rare_cnt   (rare_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: treat the signature as an integer, double it modulo 2^16,
    // fold the polynomial in when a carry leaves bit 15, then add the sample (GF(2)).
    function automatic logic [15:0] model_step(input logic [15:0] s, input logic [7:0] d);
        int unsigned v;
        v = 32'(s) * 2;
        if (v >= 65536) v = (v - 65536) ^ 32'h1021;
        v = v ^ 32'(d);
        return v[15:0];
    endfunction

    function automatic logic [15:0] model_run(input logic [15:0] seed, input int n);
        logic [15:0] s;
        s = seed;
        for (int i = 0; i < n; i++) s = model_step(s, d_arr[i]);
        return s;
    endfunction

    function automatic logic [15:0] model_rare(input int n);
        int r;
        r = 0;
        for (int i = 0; i < n; i++) if (d_arr[i][0] && r < 65535) r++;
        return 16'(r);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    exp_t m_e;
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1, expected no run outstanding (t=%0t)", $time);
            end else begin
                m_e = exp_q.pop_front();
                chk("sb_signature", 32'(signature), 32'(m_e.sig));
                chk("sb_pass", 32'(pass), 32'(m_e.pass));
                chk("sb_rare_cnt", 32'(rare_cnt), 32'(m_e.rare));
            end
        end
    end

    // One complete run using d_arr/g_arr; optionally pulses start during gap cycles.
    task automatic run(input string tag, input logic [15:0] seed, input logic [15:0] golden,
                       input int n, input bit poke);
        exp_t        e;
        logic [15:0] s;
        e.sig  = model_run(seed, n);
        e.pass = (e.sig == golden);
        e.rare = model_rare(n);
        exp_q.push_back(e);

        start      = 1'b1;
        n_patterns = 16'(n);
        sig_seed   = seed;
        golden_sig = golden;
        step();
        start = 1'b0;
        chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        chk({tag, "_seed_loaded"}, 32'(signature), 32'(seed));
        s = seed;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < g_arr[i]; g++) begin
                resp_valid = 1'b0;
                resp_data  = 8'($urandom);
                if (poke) begin
                    start      = 1'b1;
                    sig_seed   = 16'($urandom);
                    n_patterns = 16'($urandom_range(0, 2));
                end
                step();
                start = 1'b0;
                chk({tag, "_gap_hold"}, 32'(signature), 32'(s));
            end
            resp_valid = 1'b1;
            resp_data  = d_arr[i];
            step();
            resp_valid = 1'b0;
            s = model_step(s, d_arr[i]);
            chk({tag, "_step_sig"}, 32'(signature), 32'(s));
        end
        // CHECK cycle
        chk({tag, "_check_busy"}, 32'(busy), 32'd1);
        chk({tag, "_check_no_done"}, 32'(done), 32'd0);
        step();
        chk({tag, "_done_pulse"}, 32'(done), 32'd1);
        chk({tag, "_idle_at_done"}, 32'(busy), 32'd0);
        chk({tag, "_pass"}, 32'(pass), 32'(e.pass));
        step();
        chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1);
    end

    initial begin
        logic [15:0] seed;
        logic [15:0] gold;
        logic [15:0] s1;
        int          n;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; n_patterns = '0;
        sig_seed = '0; golden_sig = '0; resp_valid = 1'b0; resp_data = '0;
        for (int i = 0; i < 16; i++) begin d_arr[i] = '0; g_arr[i] = 0; end
        repeat (3) step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_signature", 32'(signature), 32'd0);
        chk("rst_rare_cnt", 32'(rare_cnt), 32'd0);
        rst_n = 1'b1;
        repeat (3) step();
        chk("post_rst_idle", 32'(busy), 32'd0);

        // Known-answer: A5 then 01 from seed 0
        d_arr[0] = 8'hA5; d_arr[1] = 8'h01;
        run("kat1", 16'h0000, 16'h014B, 2, 1'b0);
        chk("kat1_sig_final", 32'(signature), 32'h014B);
        chk("kat1_rare", 32'(rare_cnt), 32'd2);

        // Feedback taken on MSB
        d_arr[0] = 8'h00;
        run("kat2", 16'h8000, 16'h0000, 1, 1'b0);
        chk("kat2_sig", 32'(signature), 32'h1021);
        chk("kat2_pass", 32'(pass), 32'd0);

        // Zero-length runs, matching and mismatching golden
        run("zero_match", 16'h1234, 16'h1234, 0, 1'b0);
        run("zero_miss", 16'h1234, 16'h4321, 0, 1'b0);

        // resp_valid ignored in IDLE
        s1 = signature;
        resp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            resp_data = 8'($urandom) | 8'h01;
            step();
        end
        resp_valid = 1'b0;
        chk("idle_valid_sig", 32'(signature), 32'(s1));
        chk("idle_valid_busy", 32'(busy), 32'd0);

        // Gap-free vs gapped run with mid-run start pulses
        d_arr[0] = 8'h3C; d_arr[1] = 8'hC3; d_arr[2] = 8'h7F;
        gold = model_run(16'hACE1, 3);
        run("nogap", 16'hACE1, gold, 3, 1'b0);
        chk("nogap_sig", 32'(signature), 32'(gold));
        g_arr[0] = 0; g_arr[1] = 1; g_arr[2] = 5;
        run("gaps", 16'hACE1, gold, 3, 1'b1);
        chk("gaps_sig", 32'(signature), 32'(gold));
        for (int i = 0; i < 16; i++) g_arr[i] = 0;

        // Abort after first of three samples
        d_arr[0] = 8'h5B;
        start = 1'b1; n_patterns = 16'd3; sig_seed = 16'h2468; golden_sig = 16'h0;
        step(); start = 1'b0;
        resp_valid = 1'b1; resp_data = d_arr[0];
        step(); resp_valid = 1'b0;
        s1 = model_step(16'h2468, 8'h5B);
        abort = 1'b1;
        step(); abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_pass", 32'(pass), 32'd0);
        chk("abort_sig_hold", 32'(signature), 32'(s1));
        chk("abort_rare_hold", 32'(rare_cnt), 32'd1);
        repeat (4) step();
        chk("abort_still_idle", 32'(busy), 32'd0);

        // Abort during CHECK suppresses a would-be pass
        start = 1'b1; n_patterns = 16'd1; sig_seed = 16'h0000; golden_sig = 16'h005A;
        step(); start = 1'b0;
        resp_valid = 1'b1; resp_data = 8'h5A;
        step(); resp_valid = 1'b0;
        chk("abchk_in_check", 32'(busy), 32'd1);
        abort = 1'b1;
        step(); abort = 1'b0;
        chk("abchk_busy", 32'(busy), 32'd0);
        chk("abchk_pass", 32'(pass), 32'd0);
        chk("abchk_sig", 32'(signature), 32'h005A);
        repeat (3) step();

        // start+abort together in IDLE: abort wins
        start = 1'b1; abort = 1'b1; n_patterns = 16'd2; sig_seed = 16'hFFFF;
        step(); start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", 32'(busy), 32'd0);
        chk("start_abort_sig", 32'(signature), 32'h005A);

        // Reset mid-run, between edges
        start = 1'b1; n_patterns = 16'd4; sig_seed = 16'hBEEF;
        step(); start = 1'b0;
        resp_valid = 1'b1; resp_data = 8'h11;
        step(); resp_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_pass", 32'(pass), 32'd0);
        chk("mid_rst_sig", 32'(signature), 32'd0);
        chk("mid_rst_rare", 32'(rare_cnt), 32'd0);
        step();
        rst_n = 1'b1;
        repeat (2) step();
        chk("post_mid_rst_idle", 32'(busy), 32'd0);
        d_arr[0] = 8'h01; d_arr[1] = 8'h80;
        gold = model_run(16'h0F0F, 2);
        run("after_rst", 16'h0F0F, gold, 2, 1'b0);

        // Randomized runs
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 8);
            seed = 16'($urandom);
            for (int i = 0; i < n; i++) begin
                d_arr[i] = 8'($urandom);
                g_arr[i] = $urandom_range(0, 3);
            end
            gold = ($urandom_range(0, 1) == 1) ? model_run(seed, n) : 16'($urandom);
            run("rand", seed, gold, n, r[0]);
        end

        repeat (4) step();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
